// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and sizing helper for the counter block
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Bits needed to hold values 0..n-1; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - divides the enable into one tick every PRESC enabled cycles
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int PCW = (clog2(PRESC) < 1) ? 1 : clog2(PRESC);
    localparam logic [PCW-1:0] PC_LAST = PCW'(PRESC - 1);
    localparam logic [PCW-1:0] PC_ONE  = PCW'(1);

    logic [PCW-1:0] pc;

    // Enabled-cycle counter; clr/ld throw away any partial prescale.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            pc <= '0;
        end else if (en) begin
            if (pc == PC_LAST) begin
                pc <= '0;
            end else begin
                pc <= pc + PC_ONE;
            end
        end
    end

    // With PRESC == 1 every enabled cycle is a step.
    assign tick = (PRESC == 1) ? en : (en && (pc == PC_LAST));

endmodule

// File: rtl/counter_mod.sv
// rtl/counter_mod.sv - up/down modulus counter with load, prescaler, tc pulse and sticky overflow
module counter_mod
    import counter_pkg::*;
#(
    parameter int             W     = 8,
    parameter logic [W-1:0]   IV    = {W{1'b1}},
    parameter logic [W-1:0]   MAXV  = {W{1'b1}},
    parameter bit             SAT   = MODE_WRAP,
    parameter int             PRESC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    input  logic         en,
    input  logic         dir,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         ovf,
    output logic         zero
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    generate
        if (IV > MAXV) begin : g_bad_iv
            $error("counter_mod: IV must not exceed MAXV");
        end
        if (PRESC < 1) begin : g_bad_presc
            $error("counter_mod: PRESC must be at least 1");
        end
    endgenerate

    logic tick;

    counter_prescaler #(
        .PRESC(PRESC)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .restart(clr | ld),
        .tick   (tick)
    );

    // Count register: rst > clr > ld > step > hold; the range check against MAXV replaces 2^W wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q   <= IV;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (ld) begin
            q  <= (d > MAXV) ? MAXV : d;
            tc <= 1'b0;
        end else if (tick) begin
            if (dir == DIR_UP) begin
                if (q < MAXV) begin
                    q  <= q + ONE;
                    tc <= 1'b0;
                end else begin
                    q   <= (SAT == MODE_SAT) ? q : '0;
                    tc  <= 1'b1;
                    ovf <= 1'b1;
                end
            end else begin
                if (q != '0) begin
                    q  <= q - ONE;
                    tc <= 1'b0;
                end else begin
                    q   <= (SAT == MODE_SAT) ? q : MAXV;
                    tc  <= 1'b1;
                    ovf <= 1'b1;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

    assign zero = (q == '0);

endmodule

// File: tb/tb_counter_mod.sv
// tb/tb_counter_mod.sv - scoreboard bench over four counter configurations sharing one stimulus
module tb_counter_mod;

    typedef struct {
        int q;
        bit tc;
        bit ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       ld;
    logic [7:0] d;
    logic       en;
    logic       dir;

    logic [7:0] q_o   [4];
    logic       tc_o  [4];
    logic       ovf_o [4];
    logic       zero_o[4];

    // 0: wrap 0..9, 1: saturate 0..9, 2: wrap 0..9 prescale 3, 3: defaults
    int P_IV [4] = '{0, 0, 0, 255};
    int P_MAX[4] = '{9, 9, 9, 255};
    int P_SAT[4] = '{0, 1, 0, 0};
    int P_PRE[4] = '{1, 1, 3, 1};

    int m_q [4];
    bit m_tc[4];
    bit m_ovf[4];
    int m_pc[4];

    exp_t sb[$];

    int n_vec;
    int n_err;

    counter_mod #(.W(8), .IV(8'd0), .MAXV(8'd9), .SAT(1'b0), .PRESC(1)) u_dut_wrap (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .en(en), .dir(dir),
        .q(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0])
    );

    counter_mod #(.W(8), .IV(8'd0), .MAXV(8'd9), .SAT(1'b1), .PRESC(1)) u_dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .en(en), .dir(dir),
        .q(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1])
    );

    counter_mod #(.W(8), .IV(8'd0), .MAXV(8'd9), .SAT(1'b0), .PRESC(3)) u_dut_presc (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .en(en), .dir(dir),
        .q(q_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2])
    );

    counter_mod u_dut_dflt (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .en(en), .dir(dir),
        .q(q_o[3]), .tc(tc_o[3]), .ovf(ovf_o[3]), .zero(zero_o[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one configuration for one clock edge.
    task automatic model_step(input int i, input bit r, input bit c, input bit l,
                              input int dv, input bit e, input bit dr);
        bit tk;
        if (r || c) begin
            m_q[i]   = P_IV[i];
            m_tc[i]  = 1'b0;
            m_ovf[i] = 1'b0;
            m_pc[i]  = 0;
        end else if (l) begin
            m_q[i]  = (dv > P_MAX[i]) ? P_MAX[i] : dv;
            m_tc[i] = 1'b0;
            m_pc[i] = 0;
        end else begin
            tk = 1'b0;
            if (e) begin
                if (m_pc[i] == P_PRE[i] - 1) begin
                    tk = 1'b1;
                    m_pc[i] = 0;
                end else begin
                    m_pc[i] = m_pc[i] + 1;
                end
            end
            if (!tk) begin
                m_tc[i] = 1'b0;
            end else if (dr) begin
                if (m_q[i] < P_MAX[i]) begin
                    m_q[i]  = m_q[i] + 1;
                    m_tc[i] = 1'b0;
                end else begin
                    if (P_SAT[i] == 0) m_q[i] = 0;
                    m_tc[i]  = 1'b1;
                    m_ovf[i] = 1'b1;
                end
            end else begin
                if (m_q[i] > 0) begin
                    m_q[i]  = m_q[i] - 1;
                    m_tc[i] = 1'b0;
                end else begin
                    if (P_SAT[i] == 0) m_q[i] = P_MAX[i];
                    m_tc[i]  = 1'b1;
                    m_ovf[i] = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, queue expectations, then compare after the edge.
    task automatic cyc(input bit r, input bit c, input bit l, input int dv, input bit e, input bit dr);
        exp_t x;
        rst = r;
        clr = c;
        ld  = l;
        d   = dv[7:0];
        en  = e;
        dir = dr;
        for (int i = 0; i < 4; i++) begin
            model_step(i, r, c, l, dv, e, dr);
            x.q   = m_q[i];
            x.tc  = m_tc[i];
            x.ovf = m_ovf[i];
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            x = sb.pop_front();
            chk_val($sformatf("cfg%0d_q", i),    32'(q_o[i]),    32'(x.q));
            chk_val($sformatf("cfg%0d_tc", i),   32'(tc_o[i]),   32'(x.tc));
            chk_val($sformatf("cfg%0d_ovf", i),  32'(ovf_o[i]),  32'(x.ovf));
            chk_val($sformatf("cfg%0d_zero", i), 32'(zero_o[i]), 32'(x.q == 0));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 4; i++) begin
            m_q[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_pc[i] = 0;
        end
        rst = 1'b0; clr = 1'b0; ld = 1'b0; d = 8'd0; en = 1'b0; dir = 1'b1;
        #1;

        // Reset defaults
        cyc(1, 0, 0, 0, 0, 1);
        chk_val("rst_q_wrap", 32'(q_o[0]), 32'd0);
        chk_val("rst_q_dflt", 32'(q_o[3]), 32'hFF);
        chk_val("rst_tc_dflt", 32'(tc_o[3]), 32'd0);
        chk_val("rst_ovf_wrap", 32'(ovf_o[0]), 32'd0);

        // Count up through the 9 -> 0 wrap
        cyc(0, 0, 0, 0, 1, 1);
        chk_val("dflt_wrap_q", 32'(q_o[3]), 32'h00);
        chk_val("dflt_wrap_tc", 32'(tc_o[3]), 32'd1);
        chk_val("dflt_wrap_ovf", 32'(ovf_o[3]), 32'd1);
        chk_val("dflt_wrap_zero", 32'(zero_o[3]), 32'd1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        chk_val("presc_first_step", 32'(q_o[2]), 32'd1);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 1);
        chk_val("wrap_q9", 32'(q_o[0]), 32'd9);
        cyc(0, 0, 0, 0, 1, 1);
        chk_val("wrap_q0", 32'(q_o[0]), 32'd0);
        chk_val("wrap_tc", 32'(tc_o[0]), 32'd1);
        chk_val("sat_hold9", 32'(q_o[1]), 32'd9);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);

        // Down wrap / saturate from 0
        cyc(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 0);
        chk_val("sat_down_tc", 32'(tc_o[1]), 32'd1);

        // Load, clamp, load beats enable, ovf survives load
        cyc(0, 0, 1, 5, 0, 1);
        cyc(0, 0, 1, 200, 0, 1);
        chk_val("ld_clamp", 32'(q_o[0]), 32'd9);
        cyc(0, 0, 1, 3, 1, 1);
        chk_val("ld_wins", 32'(q_o[0]), 32'd3);
        chk_val("ld_keeps_ovf", 32'(ovf_o[0]), 32'd1);

        // Priority: rst+clr+ld, then clr at the limit with en
        cyc(1, 1, 1, 7, 1, 1);
        cyc(0, 0, 1, 9, 0, 1);
        cyc(0, 1, 0, 0, 1, 1);
        chk_val("clr_no_tc", 32'(tc_o[0]), 32'd0);

        // Prescaler: gaps in en and clr mid-prescale
        cyc(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 1, 1);
        for (int k = 0; k < 7; k++) cyc(0, 0, 0, 0, 1, 1);

        // Mixed random traffic
        for (int k = 0; k < 300; k++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 9) == 0), int'($urandom_range(0, 255)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
